uart_tx_drain: RTL
==================

# uart_tx_drain

Serial transmit stage that drains the 16x8 byte FIFO and shifts each byte out as an asynchronous UART frame on a single line. It sits directly downstream of the FIFO: it drives the FIFO read enable, samples the FIFO's registered read data, and owns the `tx` pin.

## Interface
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit, legal values 2..65535.
- `PARITY`, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tx_en` in 1: permits starting new frames.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in 8: FIFO read data, valid in the cycle after a read-enable cycle.
- `fifo_re` out 1: FIFO read enable, high for exactly one cycle per byte.
- `tx` out 1: serial line, idle high, registered.
- `busy` out 1: high from the pop cycle through the last stop-bit cycle.
- `frame_done` out 1: one-cycle pulse in the last cycle of the final stop bit.

## Operation
- States: IDLE, POP, LOAD, START, DATA, PAR, STOP.
- IDLE -> POP when `tx_en` = 1 and `fifo_empty` = 0 at the edge. Otherwise stay in IDLE.
- POP lasts one cycle. `fifo_re` = 1 only in POP and is decoded from the state register, so it is glitch-free. POP -> LOAD.
- LOAD lasts one cycle. `fifo_dout` is captured into the 8-bit shift register and parity is computed. LOAD -> START.
- START: `tx` = 0.
- DATA: 8 bits, LSB first. A 3-bit index counts 0..7.
- PAR: present only when `PARITY` != 0.
  - Even mode: bit = XOR of the data bits.
  - Odd mode: bit = inverted XOR of the data bits.
- STOP: `tx` = 1 for `STOP_BITS` bit periods.
- End of STOP:
  - If `tx_en` = 1 and `fifo_empty` = 0, go straight to POP (back-to-back frames).
  - Otherwise go to IDLE.
- `tx_en` falling mid-frame: the current frame completes and no further pop occurs.
- `fifo_empty` is sampled only in IDLE and in the final STOP cycle. `fifo_re` is never asserted while `fifo_empty` = 1.
- Baud counter:
  - Width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
  - It is cleared on entry to START.
- Reset values: `tx` = 1, `fifo_re` = 0, `busy` = 0, `frame_done` = 0, state = IDLE, counters = 0, shift register = 0.
- Reset mid-frame: `tx` returns to 1 in the cycle after the reset edge. The in-flight byte is lost and is not re-read.

## Timing
- Cycle numbering:
  - C0 is the edge where IDLE samples `tx_en` = 1 and `fifo_empty` = 0.
  - C1 is POP (`fifo_re` = 1, `busy` = 1).
  - C2 is LOAD; `fifo_dout` is valid and is captured at the end of C2.
- The start bit is driven on `tx` from C3 for `CLKS_PER_BIT` cycles.
- Frame length in bits: N = 1 + 8 + (`PARITY` != 0) + `STOP_BITS`. `tx` is framed for N x `CLKS_PER_BIT` cycles starting at C3.
- `frame_done` is high in cycle C3 + N x `CLKS_PER_BIT` - 1.
- Back-to-back frames: the next POP follows the last stop cycle immediately. The inter-frame gap on `tx` is exactly 2 cycles high (POP, LOAD) beyond the stop bits.
- `busy` stays high across back-to-back frames, including the POP and LOAD cycles between them.
- Worst-case pop rate: one byte per N x `CLKS_PER_BIT` + 2 cycles.

## Test plan
- **Single byte.** `CLKS_PER_BIT` = 4, `PARITY` = 0, `STOP_BITS` = 1; FIFO holds 0xA5; `tx_en` = 1.
  - One `fifo_re` pulse.
  - `tx` bits = 0,1,0,1,0,0,1,0,1,1, each 4 cycles, start bit beginning 2 cycles after `fifo_re`.
  - `frame_done` in cycle 39 after start; then IDLE with `busy` = 0.
- **Back-to-back.** FIFO holds 0x00, 0xFF, 0x3C.
  - Exactly 3 `fifo_re` pulses, each 42 cycles apart; bytes decoded in order.
  - `busy` continuously high; `fifo_re` never asserted once `fifo_empty` = 1.
- **Parity.**
  - `PARITY` = 1, byte 0x07: parity bit = 1.
  - `PARITY` = 2, byte 0x07: parity bit = 0.
  - `STOP_BITS` = 2: line stays high 8 cycles before `frame_done`.
- **Gating.**
  - `tx_en` = 0 with a non-empty FIFO: no `fifo_re` and `tx` = 1 for 100 cycles.
  - Drop `tx_en` during DATA: the frame finishes and no second pop occurs.
- **Reset mid-frame.** Assert `rst` during data bit 3.
  - Next cycle: `tx` = 1, `busy` = 0, `fifo_re` = 0.
  - After release, the next FIFO byte is sent with correct framing.
- **Empty.** `fifo_empty` held at 1 with `tx_en` = 1 for 200 cycles: `fifo_re`, `busy` and `frame_done` all stay 0.

Source files
------------

// File: rtl/uart_tx_drain.sv
// UART transmit stage: pops one byte per frame from the upstream FIFO and serialises it
// as start + 8 data bits (LSB first) + optional parity + 1/2 stop bits on a registered tx line.
module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_re,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PAR, STOP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_idx;
  logic            stop_idx;
  logic [7:0]      shift_reg;
  logic [7:0]      shift_nxt;
  logic            par_bit;
  logic            tx_nxt;
  logic            bit_end;
  logic            last_stop;
  logic            can_pop;

  assign bit_end   = (baud == BAUD_MAX);
  assign last_stop = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  assign can_pop   = tx_en && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (can_pop) state_nxt = POP;
      POP:   state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:   if (bit_end) state_nxt = STOP;
      STOP:  if (last_stop) state_nxt = can_pop ? POP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx is registered, so its next value is decoded from the next state and next shift contents
  always_comb begin
    fifo_re    = (state == POP);
    busy       = (state != IDLE);
    frame_done = last_stop;
    shift_nxt  = shift_reg;
    if (state == LOAD)
      shift_nxt = fifo_dout;
    else if (state == DATA && bit_end)
      shift_nxt = {1'b0, shift_reg[7:1]};
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PAR:     tx_nxt = par_bit;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx        <= 1'b1;
      baud      <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      tx        <= tx_nxt;
      shift_reg <= shift_nxt;
      if (state == LOAD)
        par_bit <= (^fifo_dout) ^ (PARITY == 2);
      if (state == START || state == DATA || state == PAR || state == STOP)
        baud <= bit_end ? '0 : baud + BW'(1);
      else
        baud <= '0;
      if (state != DATA)
        bit_idx <= '0;
      else if (bit_end)
        bit_idx <= bit_idx + 3'd1;
      if (state != STOP)
        stop_idx <= 1'b0;
      else if (bit_end)
        stop_idx <= ~last_stop;
    end
  end

endmodule
